// File: rtl/bram_dp.sv
// bram_dp: dual-port block RAM (port A byte-writable R/W, port B read-only) that zeroes
// every word after reset. Define BRAM_OUTREG_EN to add a second output register stage on both ports.
module bram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH_LOG2 = 13,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clka,
  input  logic                    rsta_n,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   douta,
  input  logic                    enb,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    busy
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] clr_cnt_reg, clr_cnt_next;
  logic                  busy_reg, busy_next;
  logic                  run;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_a, idx_b, wr_idx;
  logic [NBYTES-1:0]     wr_lane;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_a_old, rd_a_merged, rd_a_sel, rd_b;
  logic [DATA_WIDTH-1:0] douta_s1_reg, doutb_s1_reg;

  assign run   = (state_reg == ST_RUN);
  assign idx_a = addra[DEPTH_LOG2-1:0];
  assign idx_b = addrb[DEPTH_LOG2-1:0];
  assign busy  = busy_reg;

  // Clear engine state register
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    busy_next    = busy_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt_reg + DEPTH_LOG2'(1);
        busy_next    = 1'b1;
        if (&clr_cnt_reg) begin
          state_next = ST_RUN;
          busy_next  = 1'b0;
        end
      end
      ST_RUN: begin
        busy_next = 1'b0;
      end
      default: begin
        state_next = ST_CLEAR;
        busy_next  = 1'b1;
      end
    endcase
  end

  // The single write port is shared between the clear sweep and user port A.
  always_comb begin
    wr_idx  = clr_cnt_reg;
    wr_lane = '1;
    wr_data = '0;
    if (run) begin
      wr_idx  = idx_a;
      wr_lane = ena ? wea : '0;
      wr_data = dina;
    end
  end

  always_ff @(posedge clka) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_lane[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_a_old = mem[idx_a];
  assign rd_b     = mem[idx_b];

  // Write-first view of port A: written lanes from dina, the rest from memory.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign rd_a_merged[8*gi +: 8] = wea[gi] ? dina[8*gi +: 8] : rd_a_old[8*gi +: 8];
    end
  endgenerate

  generate
    if (RDW_MODE != 0) begin : g_wr_first
      assign rd_a_sel = rd_a_merged;
    end else begin : g_rd_first
      assign rd_a_sel = rd_a_old;
    end
  endgenerate

  // First read stage; port B always sees pre-write contents on a collision.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      douta_s1_reg <= '0;
      doutb_s1_reg <= '0;
    end else if (!run) begin
      douta_s1_reg <= '0;
      doutb_s1_reg <= '0;
    end else begin
      if (ena) begin
        douta_s1_reg <= rd_a_sel;
      end
      if (enb) begin
        doutb_s1_reg <= rd_b;
      end
    end
  end

`ifdef BRAM_OUTREG_EN
  logic                  ena_d_reg, enb_d_reg;
  logic [DATA_WIDTH-1:0] douta_s2_reg, doutb_s2_reg;

  // Second stage follows the first only when that port was enabled last cycle.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      ena_d_reg    <= 1'b0;
      enb_d_reg    <= 1'b0;
      douta_s2_reg <= '0;
      doutb_s2_reg <= '0;
    end else if (!run) begin
      ena_d_reg    <= 1'b0;
      enb_d_reg    <= 1'b0;
      douta_s2_reg <= '0;
      doutb_s2_reg <= '0;
    end else begin
      ena_d_reg <= ena;
      enb_d_reg <= enb;
      if (ena_d_reg) begin
        douta_s2_reg <= douta_s1_reg;
      end
      if (enb_d_reg) begin
        doutb_s2_reg <= doutb_s1_reg;
      end
    end
  end

  assign douta = douta_s2_reg;
  assign doutb = doutb_s2_reg;
`else
  assign douta = douta_s1_reg;
  assign doutb = doutb_s1_reg;
`endif

endmodule
